pairing_host_bridge: RTL and testbench
======================================

# pairing_host_bridge

Host-side loader/unloader that sits directly upstream of the pairing core's external memory ports. It receives operand words on a valid/ready input stream, packs them into full memory entries, and writes them through the core's external write port. It then pulses the core's run input with a function code and waits for the end flag. Finally it reads a result window back through the external read port and serializes it onto a valid/ready output stream.

## Interface
- WORD_W, 64: host stream word width.
- ENTRY_W, 512: memory entry width. Must equal the bit width of one redundant_poly_L3 entry.
- ADDR_W, 10: core external address width.
- RD_LAT, 2: cycles from read address to valid read data on the core read port.
- TIMEOUT, 2^24-1: maximum WAIT cycles before the error exit.
- WPE (derived) = ceil(ENTRY_W/WORD_W): words per entry.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; accepted only in IDLE.
- func  in  4  function code forwarded to core_n_func.
- in_base / out_base  in  ADDR_W  first entry address for load / readback.
- in_count / out_count  in  ADDR_W  number of entries to load / read back.
- s_valid, s_data[WORD_W], s_last  in  input word stream.
- s_ready  out  1  input stream ready.
- m_valid, m_data[WORD_W], m_last  out  output word stream.
- m_ready  in  1  output stream ready.
- core_extin_en  out  1  core external write enable.
- core_extin_addr  out  ADDR_W  core external write address.
- core_extin_data  out  ENTRY_W  core external write data.
- core_extout_addr  out  ADDR_W  core external read address.
- core_run  out  1  core start pulse.
- core_n_func  out  4  function code to the core.
- core_extout_data  in  ENTRY_W  core external read data.
- core_endflag, core_busy  in  1  core status.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  sticky error flag; cleared by the next accepted start.

## Operation
- States: IDLE, LOAD, RUN, WAIT, FETCH, SEND, DONE.
- IDLE:
  - On start, latch func, bases and counts, and clear err.
  - Go to LOAD if in_count≠0; otherwise go to RUN.
- LOAD:
  - s_ready=1 while the entry buffer is not full.
  - Word k of an entry fills bits [k·WORD_W +: WORD_W]; the first word is least significant.
  - Bits above ENTRY_W in the last word are discarded.
  - On the WPE-th word, the next cycle drives core_extin_en=1 for exactly one cycle with addr = in_base + entry_idx (mod 2^ADDR_W) and data = the packed entry.
  - s_ready=0 during that write cycle.
  - s_last must coincide with the final word of entry in_count-1.
  - Early s_last: set err, drop the partial entry (not written), go to DONE.
  - Final word without s_last: set err but complete the write, then go to RUN.
- RUN: core_run=1 for one cycle; core_n_func holds the latched func throughout the command. Go to WAIT.
- WAIT:
  - Sample core_endflag starting the cycle after core_run; a high endflag in the core_run cycle itself is ignored.
  - On endflag, go to FETCH if out_count≠0, else to DONE.
  - Count cycles in WAIT; reaching TIMEOUT sets err and goes to DONE.
- FETCH:
  - Drive core_extout_addr = out_base + entry_idx (mod 2^ADDR_W) and hold it.
  - After RD_LAT cycles, capture core_extout_data into the output shift register and go to SEND.
- SEND:
  - Present words LSB-first; m_valid=1.
  - A word advances only when m_valid & m_ready.
  - m_last=1 on the final word of entry out_count-1.
  - After WPE words, go to FETCH for the next entry or to DONE.
  - m_valid, m_data and m_last stay stable while m_ready=0.
- DONE: done=1 for one cycle, then IDLE.
- start outside IDLE is ignored.
- core_extout_addr is held at out_base when not in FETCH/SEND.
- Entry-index counters are ADDR_W wide. in_count = 2^ADDR_W is not representable; the maximum is 2^ADDR_W-1.

## Timing
- Reset values:
  - s_ready, m_valid, m_last, core_extin_en, core_run, done, err are 0.
  - All data and address outputs are 0.
  - State is IDLE.
- rst mid-command returns to IDLE the next cycle and drops all partial data. No further core_extin_en or core_run is issued.
- Load throughput: WPE+1 cycles per entry with s_valid held high.
- start to core_run: in_count·(WPE+1)+2 cycles with continuous input; 2 cycles when in_count=0.
- Endflag to first m_valid: RD_LAT+2 cycles.
- Readback throughput: RD_LAT+1+WPE cycles per entry with m_ready held high.
- All outputs are registered; there is no combinational path from s_valid or m_ready to any output.

## Test plan
- Load with WORD_W=64, ENTRY_W=512, in_base=0x010, in_count=2, 16 words 0..15, s_last on word 15 → two writes: addr 0x010 carrying words 0..7 (word 0 in bits [63:0]), addr 0x011 carrying words 8..15; then core_run pulse with core_n_func=func.
- Model endflag 50 cycles after core_run with out_count=1 and out_base=0x3FF → FETCH addr 0x3FF; 8 output words, LSB word first, m_last on word 8; done pulse.
- Random m_ready throttling (50%) over out_count=3 → 24 words in order; data stable while stalled; exactly one m_last.
- Early s_last on word 5 of in_count=1 → no core_extin_en, no core_run, err=1, done pulse.
- Endflag asserted in the core_run cycle and never again, TIMEOUT=100 → err=1 after 100 WAIT cycles, no readback.
- rst asserted during SEND → next cycle m_valid=0, state IDLE; a following start runs cleanly with err=0.

Source files
------------

// File: rtl/pairing_host_bridge.sv
// Host-side loader/unloader for the pairing core: packs stream words into memory
// entries, launches a core function, then serializes the result window back out.
module pairing_host_bridge #(
    parameter int WORD_W  = 64,
    parameter int ENTRY_W = 512,
    parameter int ADDR_W  = 10,
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 16777215
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         func,
    input  logic [ADDR_W-1:0]  in_base,
    input  logic [ADDR_W-1:0]  in_count,
    input  logic [ADDR_W-1:0]  out_base,
    input  logic [ADDR_W-1:0]  out_count,
    input  logic               s_valid,
    input  logic [WORD_W-1:0]  s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic               m_valid,
    output logic [WORD_W-1:0]  m_data,
    output logic               m_last,
    input  logic               m_ready,
    output logic               core_extin_en,
    output logic [ADDR_W-1:0]  core_extin_addr,
    output logic [ENTRY_W-1:0] core_extin_data,
    output logic [ADDR_W-1:0]  core_extout_addr,
    output logic               core_run,
    output logic [3:0]         core_n_func,
    input  logic [ENTRY_W-1:0] core_extout_data,
    input  logic               core_endflag,
    input  logic               core_busy,
    output logic               done,
    output logic               err
);

    localparam int WPE   = (ENTRY_W + WORD_W - 1) / WORD_W;
    localparam int BUF_W = WPE * WORD_W;
    localparam int WC_W  = $clog2(WPE + 1);
    localparam int RC_W  = $clog2(RD_LAT + 2);
    localparam int TC_W  = $clog2(TIMEOUT + 1);

    localparam logic [WC_W-1:0] WLAST = WC_W'(WPE - 1);
    localparam logic [RC_W-1:0] RLAST = RC_W'(RD_LAT);
    localparam logic [TC_W-1:0] TLAST = TC_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FETCH = 3'd4;
    localparam logic [2:0] S_SEND  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0]         state_r;
    logic [3:0]         func_r;
    logic [ADDR_W-1:0]  in_base_r;
    logic [ADDR_W-1:0]  in_count_r;
    logic [ADDR_W-1:0]  out_base_r;
    logic [ADDR_W-1:0]  out_count_r;
    logic [ADDR_W-1:0]  entry_idx_r;
    logic [WC_W-1:0]    word_idx_r;
    logic [RC_W-1:0]    lat_cnt_r;
    logic [TC_W-1:0]    to_cnt_r;
    logic [BUF_W-1:0]   ibuf_r;
    logic [BUF_W-1:0]   obuf_r;
    logic               s_ready_r;
    logic               m_valid_r;
    logic               m_last_r;
    logic               ext_en_r;
    logic [ADDR_W-1:0]  ext_addr_r;
    logic [ADDR_W-1:0]  rd_addr_r;
    logic               run_r;
    logic               done_r;
    logic               err_r;

    logic               word_last_s;
    logic               in_last_s;
    logic               out_last_s;
    logic               in_hs_s;
    logic               out_hs_s;
    logic [ADDR_W-1:0]  entry_next_s;
    logic [WC_W-1:0]    word_next_s;
    logic               unused_s;

    assign word_last_s  = (word_idx_r == WLAST);
    assign in_last_s    = (entry_idx_r == (in_count_r - ADDR_W'(1'b1)));
    assign out_last_s   = (entry_idx_r == (out_count_r - ADDR_W'(1'b1)));
    assign in_hs_s      = s_valid & s_ready_r;
    assign out_hs_s     = m_valid_r & m_ready;
    assign entry_next_s = entry_idx_r + ADDR_W'(1'b1);
    assign word_next_s  = word_idx_r + WC_W'(1'b1);
    assign unused_s     = core_busy;

    assign s_ready          = s_ready_r;
    assign m_valid          = m_valid_r;
    assign m_data           = obuf_r[WORD_W-1:0];
    assign m_last           = m_last_r;
    assign core_extin_en    = ext_en_r;
    assign core_extin_addr  = ext_addr_r;
    assign core_extin_data  = ibuf_r[ENTRY_W-1:0];
    assign core_extout_addr = rd_addr_r;
    assign core_run         = run_r;
    assign core_n_func      = func_r;
    assign done             = done_r;
    assign err              = err_r;

    // Command sequencer: state, counters, buffers and every registered output
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            func_r      <= 4'd0;
            in_base_r   <= {ADDR_W{1'b0}};
            in_count_r  <= {ADDR_W{1'b0}};
            out_base_r  <= {ADDR_W{1'b0}};
            out_count_r <= {ADDR_W{1'b0}};
            entry_idx_r <= {ADDR_W{1'b0}};
            word_idx_r  <= {WC_W{1'b0}};
            lat_cnt_r   <= {RC_W{1'b0}};
            to_cnt_r    <= {TC_W{1'b0}};
            ibuf_r      <= {BUF_W{1'b0}};
            obuf_r      <= {BUF_W{1'b0}};
            s_ready_r   <= 1'b0;
            m_valid_r   <= 1'b0;
            m_last_r    <= 1'b0;
            ext_en_r    <= 1'b0;
            ext_addr_r  <= {ADDR_W{1'b0}};
            rd_addr_r   <= {ADDR_W{1'b0}};
            run_r       <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            ext_en_r <= 1'b0;
            run_r    <= 1'b0;
            done_r   <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        func_r      <= func;
                        in_base_r   <= in_base;
                        in_count_r  <= in_count;
                        out_base_r  <= out_base;
                        out_count_r <= out_count;
                        rd_addr_r   <= out_base;
                        entry_idx_r <= {ADDR_W{1'b0}};
                        word_idx_r  <= {WC_W{1'b0}};
                        err_r       <= 1'b0;
                        if (in_count != {ADDR_W{1'b0}}) begin
                            state_r   <= S_LOAD;
                            s_ready_r <= 1'b1;
                        end else begin
                            state_r <= S_RUN;
                        end
                    end
                end
                S_LOAD: begin
                    if (ext_en_r) begin
                        // write cycle just finished: next entry or launch the core
                        if (in_last_s) begin
                            state_r <= S_RUN;
                        end else begin
                            entry_idx_r <= entry_next_s;
                            s_ready_r   <= 1'b1;
                        end
                    end else if (in_hs_s) begin
                        for (int k = 0; k < WPE; k++) begin
                            if (word_idx_r == WC_W'(k)) begin
                                ibuf_r[k*WORD_W +: WORD_W] <= s_data;
                            end
                        end
                        word_idx_r <= word_last_s ? {WC_W{1'b0}} : word_next_s;
                        if (s_last && !(word_last_s && in_last_s)) begin
                            err_r     <= 1'b1;
                            s_ready_r <= 1'b0;
                            done_r    <= 1'b1;
                            state_r   <= S_DONE;
                        end else if (word_last_s) begin
                            ext_en_r   <= 1'b1;
                            ext_addr_r <= in_base_r + entry_idx_r;
                            s_ready_r  <= 1'b0;
                            if (in_last_s && !s_last) begin
                                err_r <= 1'b1;
                            end
                        end
                    end
                end
                S_RUN: begin
                    run_r    <= 1'b1;
                    to_cnt_r <= {TC_W{1'b0}};
                    state_r  <= S_WAIT;
                end
                S_WAIT: begin
                    // run_r is still high in the first WAIT cycle, masking a stale endflag
                    if (core_endflag && !run_r) begin
                        if (out_count_r != {ADDR_W{1'b0}}) begin
                            entry_idx_r <= {ADDR_W{1'b0}};
                            lat_cnt_r   <= {RC_W{1'b0}};
                            rd_addr_r   <= out_base_r;
                            state_r     <= S_FETCH;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end
                    end else if (to_cnt_r == TLAST) begin
                        err_r   <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        to_cnt_r <= to_cnt_r + TC_W'(1'b1);
                    end
                end
                S_FETCH: begin
                    if (lat_cnt_r == RLAST) begin
                        obuf_r     <= BUF_W'(core_extout_data);
                        m_valid_r  <= 1'b1;
                        m_last_r   <= out_last_s && (WLAST == {WC_W{1'b0}});
                        word_idx_r <= {WC_W{1'b0}};
                        state_r    <= S_SEND;
                    end else begin
                        lat_cnt_r <= lat_cnt_r + RC_W'(1'b1);
                    end
                end
                S_SEND: begin
                    if (out_hs_s) begin
                        if (word_last_s) begin
                            m_valid_r <= 1'b0;
                            m_last_r  <= 1'b0;
                            if (out_last_s) begin
                                rd_addr_r <= out_base_r;
                                done_r    <= 1'b1;
                                state_r   <= S_DONE;
                            end else begin
                                entry_idx_r <= entry_next_s;
                                rd_addr_r   <= out_base_r + entry_next_s;
                                lat_cnt_r   <= {RC_W{1'b0}};
                                state_r     <= S_FETCH;
                            end
                        end else begin
                            obuf_r     <= obuf_r >> WORD_W;
                            word_idx_r <= word_next_s;
                            m_last_r   <= out_last_s && (word_next_s == WLAST);
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r   <= S_IDLE;
                    s_ready_r <= 1'b0;
                    m_valid_r <= 1'b0;
                    m_last_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pairing_host_bridge.sv
// Self-checking bench for pairing_host_bridge: table-driven commands with write/readback
// scoreboards, plus hand sequences for early s_last, timeout and reset during SEND.
module tb_pairing_host_bridge;

    localparam int WORD_W  = 64;
    localparam int ENTRY_W = 512;
    localparam int ADDR_W  = 10;
    localparam int RD_LAT  = 2;
    localparam int TIMEOUT = 100;
    localparam int WPE     = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [3:0]         func;
    logic [ADDR_W-1:0]  in_base, in_count, out_base, out_count;
    logic               s_valid, s_last, s_ready;
    logic [WORD_W-1:0]  s_data;
    logic               m_valid, m_last, m_ready;
    logic [WORD_W-1:0]  m_data;
    logic               core_extin_en, core_run, core_endflag, core_busy, done, err;
    logic [ADDR_W-1:0]  core_extin_addr, core_extout_addr;
    logic [ENTRY_W-1:0] core_extin_data, core_extout_data, rd_p1;
    logic [3:0]         core_n_func;

    pairing_host_bridge #(
        .WORD_W(WORD_W), .ENTRY_W(ENTRY_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .func(func),
        .in_base(in_base), .in_count(in_count), .out_base(out_base), .out_count(out_count),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .core_extin_en(core_extin_en), .core_extin_addr(core_extin_addr),
        .core_extin_data(core_extin_data), .core_extout_addr(core_extout_addr),
        .core_run(core_run), .core_n_func(core_n_func), .core_extout_data(core_extout_data),
        .core_endflag(core_endflag), .core_busy(core_busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        func;
        logic [ADDR_W-1:0] in_base;
        logic [ADDR_W-1:0] in_count;
        logic [ADDR_W-1:0] out_base;
        logic [ADDR_W-1:0] out_count;
        int                ready_mode;
        int                ef_delay;
        bit                no_last;
        int                exp_run_lat;
        bit                exp_err;
        int                exp_last;
    } vec_t;

    typedef struct { logic [ADDR_W-1:0] addr; logic [ENTRY_W-1:0] data; } wr_t;
    typedef struct { logic [WORD_W-1:0] data; logic last; } ow_t;

    wr_t wr_q[$];
    ow_t out_q[$];
    vec_t tbl[4];

    int checks = 0, errors = 0, cyc = 0;
    int ef_mode = 0, ef_delay = 10, rdy_mode = 0;
    int start_cyc = 0, exp_run_lat = -1, run_cnt = 0, run_cyc = 0, wr_cnt = 0;
    int word_cnt = 0, last_cnt = 0, ef_cyc = 0, done_cyc = 0;
    bit ef_pending = 1'b0;
    logic [3:0] exp_func = 4'd0;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0, prev_rst = 1'b1;
    logic [WORD_W-1:0] prev_data = 64'd0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pat(input logic [ADDR_W-1:0] a, input int k);
        return {16'hD00D, 6'd0, a, 24'd0, 8'(k)};
    endfunction

    function automatic logic [ENTRY_W-1:0] rd_entry(input logic [ADDR_W-1:0] a);
        logic [ENTRY_W-1:0] r;
        for (int k = 0; k < WPE; k++) r[k*WORD_W +: WORD_W] = pat(a, k);
        return r;
    endfunction

    function automatic logic [63:0] sw(input int j, input int tag);
        return {8'hA0, 8'(tag), 16'd0, 32'(j)};
    endfunction

    task automatic chk(input string name, input logic [ENTRY_W-1:0] act, input logic [ENTRY_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // core read port: data valid RD_LAT cycles after the address
    always @(posedge clk) begin
        rd_p1            <= rd_entry(core_extout_addr);
        core_extout_data <= rd_p1;
    end

    // core endflag model
    initial begin
        core_endflag = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (core_run === 1'b1) begin
                if (ef_mode == 1) begin
                    core_endflag = 1'b1;
                    @(posedge clk); #1;
                    core_endflag = 1'b0;
                end else begin
                    repeat (ef_delay) @(posedge clk);
                    #1;
                    core_endflag = 1'b1;
                    ef_cyc = cyc;
                    ef_pending = 1'b1;
                    @(posedge clk); #1;
                    core_endflag = 1'b0;
                end
            end
        end
    end

    // m_ready driver: 0 always ready, 1 random 50%, 2 held low
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       m_ready = 1'($urandom_range(0, 1));
                2:       m_ready = 1'b0;
                default: m_ready = 1'b1;
            endcase
        end
    end

    // monitor on the falling edge
    always @(negedge clk) begin
        if (core_extin_en === 1'b1) begin
            wr_t w;
            wr_cnt++;
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                w = wr_q.pop_front();
                chk("wr_addr", core_extin_addr, w.addr);
                chk("wr_data", core_extin_data, w.data);
            end
        end
        if (core_run === 1'b1) begin
            run_cnt++;
            run_cyc = cyc;
            chk("core_n_func", core_n_func, exp_func);
            if (exp_run_lat >= 0) chk("start_to_run", cyc - start_cyc, exp_run_lat);
        end
        if (m_valid === 1'b1 && prev_valid !== 1'b1 && ef_pending) begin
            chk("endflag_to_mvalid", cyc - ef_cyc, RD_LAT + 2);
            ef_pending = 1'b0;
        end
        if (prev_valid === 1'b1 && prev_ready === 1'b0 && prev_rst === 1'b0) begin
            chk("stall_valid", m_valid, 1'b1);
            chk("stall_data", m_data, prev_data);
            chk("stall_last", m_last, prev_last);
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            ow_t o;
            word_cnt++;
            if (m_last === 1'b1) last_cnt++;
            if (out_q.size() == 0) begin
                chk("unexpected_word", 1, 0);
            end else begin
                o = out_q.pop_front();
                chk("m_data", m_data, o.data);
                chk("m_last", m_last, o.last);
            end
        end
        prev_valid = m_valid;
        prev_ready = m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        prev_rst   = rst;
    end

    task automatic issue_start(input logic [3:0] f, input logic [ADDR_W-1:0] ib, input logic [ADDR_W-1:0] ic,
                               input logic [ADDR_W-1:0] ob, input logic [ADDR_W-1:0] oc);
        @(posedge clk); #1;
        start = 1'b1; func = f; in_base = ib; in_count = ic; out_base = ob; out_count = oc;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_words(input int n_words, input int tag, input int last_at);
        for (int j = 0; j < n_words; j++) begin
            int t = 0;
            bit acc = 1'b0;
            s_valid = 1'b1;
            s_data  = sw(j, tag);
            s_last  = (j == last_at);
            while (!acc && t < 200) begin
                acc = s_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) chk("s_accept_timeout", 0, 1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 64'd0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_seen", done, 1'b1);
        done_cyc = cyc;
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
    endtask

    task automatic run_cmd(input vec_t v, input int tag);
        int wc0, lc0, rc0, wr0;
        for (int e = 0; e < int'(v.in_count); e++) begin
            wr_t w;
            w.addr = v.in_base + 10'(e);
            for (int k = 0; k < WPE; k++) w.data[k*WORD_W +: WORD_W] = sw(e * WPE + k, tag);
            wr_q.push_back(w);
        end
        for (int e = 0; e < int'(v.out_count); e++) begin
            for (int k = 0; k < WPE; k++) begin
                ow_t o;
                o.data = pat(v.out_base + 10'(e), k);
                o.last = (e == int'(v.out_count) - 1) && (k == WPE - 1);
                out_q.push_back(o);
            end
        end
        wc0 = word_cnt; lc0 = last_cnt; rc0 = run_cnt; wr0 = wr_cnt;
        ef_mode = 0; ef_delay = v.ef_delay; rdy_mode = v.ready_mode;
        exp_func = v.func; exp_run_lat = v.exp_run_lat;
        issue_start(v.func, v.in_base, v.in_count, v.out_base, v.out_count);
        if (v.in_count != 10'd0)
            send_words(int'(v.in_count) * WPE, tag, v.no_last ? -1 : int'(v.in_count) * WPE - 1);
        wait_done(3000);
        chk("cmd_err", err, v.exp_err);
        chk("cmd_runs", run_cnt - rc0, 1);
        chk("cmd_writes", wr_cnt - wr0, int'(v.in_count));
        chk("cmd_words", word_cnt - wc0, int'(v.out_count) * WPE);
        chk("cmd_last_count", last_cnt - lc0, v.exp_last);
        chk("cmd_wr_left", wr_q.size(), 0);
        chk("cmd_out_left", out_q.size(), 0);
        rdy_mode = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench timed out");
    end

    initial begin
        int rc0, wr0, wc0;
        //        func   in_base  in_cnt  out_base out_cnt rdy ef  nolast lat err last
        tbl[0] = '{4'h5, 10'h010, 10'd2, 10'h3FF, 10'd1, 0, 50, 1'b0, 20, 1'b0, 1};
        tbl[1] = '{4'hA, 10'h3FF, 10'd2, 10'h3FE, 10'd3, 1, 10, 1'b0, 20, 1'b0, 1};
        tbl[2] = '{4'h3, 10'h100, 10'd0, 10'h020, 10'd0, 0, 5,  1'b0, 2,  1'b0, 0};
        tbl[3] = '{4'hC, 10'h200, 10'd1, 10'h040, 10'd2, 0, 20, 1'b1, 11, 1'b1, 1};

        rst = 1'b1; start = 1'b0; func = 4'd0; in_base = 10'd0; in_count = 10'd0;
        out_base = 10'd0; out_count = 10'd0; s_valid = 1'b0; s_data = 64'd0; s_last = 1'b0;
        core_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_extin_en", core_extin_en, 1'b0);
        chk("rst_extin_addr", core_extin_addr, 10'd0);
        chk("rst_extin_data", core_extin_data, 512'd0);
        chk("rst_extout_addr", core_extout_addr, 10'd0);
        chk("rst_run", core_run, 1'b0);
        chk("rst_func", core_n_func, 4'd0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_cmd(tbl[i], i + 1);

        // early s_last on word index 5 of a single-entry load
        rc0 = run_cnt; wr0 = wr_cnt;
        exp_func = 4'h7; exp_run_lat = -1; ef_mode = 0; ef_delay = 10;
        issue_start(4'h7, 10'h050, 10'd1, 10'h060, 10'd1);
        send_words(6, 9, 5);
        wait_done(100);
        chk("early_err", err, 1'b1);
        chk("early_no_run", run_cnt - rc0, 0);
        chk("early_no_write", wr_cnt - wr0, 0);
        chk("early_s_ready", s_ready, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("early_still_no_run", run_cnt - rc0, 0);

        // endflag only in the core_run cycle: timeout with no readback
        wc0 = word_cnt; rc0 = run_cnt;
        exp_func = 4'h9; exp_run_lat = 2; ef_mode = 1;
        issue_start(4'h9, 10'h000, 10'd0, 10'h070, 10'd1);
        repeat (51) @(posedge clk);
        #1;
        chk("err_before_timeout", err, 1'b0);
        wait_done(200);
        chk("timeout_cycles", done_cyc - run_cyc, TIMEOUT);
        chk("timeout_err", err, 1'b1);
        chk("timeout_runs", run_cnt - rc0, 1);
        chk("timeout_no_words", word_cnt - wc0, 0);
        ef_mode = 0;

        // reset while SEND is stalled, then a clean command
        exp_func = 4'h2; exp_run_lat = 2; ef_delay = 5; rdy_mode = 2;
        issue_start(4'h2, 10'h000, 10'd0, 10'h123, 10'd2);
        begin
            int n = 0;
            while (m_valid !== 1'b1 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("rst_test_mvalid_seen", m_valid, 1'b1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_m_valid", m_valid, 1'b0);
        chk("midrst_m_last", m_last, 1'b0);
        chk("midrst_s_ready", s_ready, 1'b0);
        chk("midrst_extout_addr", core_extout_addr, 10'd0);
        chk("midrst_func", core_n_func, 4'd0);
        rdy_mode = 0;
        out_q.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("midrst_idle_valid", m_valid, 1'b0);
        chk("midrst_idle_done", done, 1'b0);
        run_cmd(tbl[0], 12);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
